// File: rtl/tmds_phase_controller.sv
// TMDS bit-clock phase controller: scans every selectable phase, counts channel-0
// control words in a fixed window per phase, locks on the best one and watches for loss.
module tmds_phase_controller #(
    parameter int PHASES        = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int DWELL_BITS    = 10,
    parameter int MIN_HITS      = 8,
    parameter int TIMEOUT_BITS  = 18
) (
    input  logic                  hdmi_clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic [9:0]            in,
    output logic [2:0]            phase,
    output logic                  valid,
    output logic                  scanning,
    output logic [DWELL_BITS:0]   best_hits,
    output logic [7:0]            loss_count
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_EVAL    = 3'd3;
    localparam logic [2:0] ST_DECIDE  = 3'd4;
    localparam logic [2:0] ST_APPLY   = 3'd5;
    localparam logic [2:0] ST_LOCKED  = 3'd6;

    localparam int                    SETTLE_W     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_ONE   = SETTLE_W'(1);
    localparam logic [2:0]            PHASE_LAST   = 3'(PHASES - 1);
    localparam logic [DWELL_BITS-1:0] DWELL_ONE    = DWELL_BITS'(1);
    localparam logic [DWELL_BITS:0]   HITS_ONE     = (DWELL_BITS + 1)'(1);
    localparam logic [DWELL_BITS:0]   MIN_HITS_C   = (DWELL_BITS + 1)'(MIN_HITS);
    localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_ONE = TIMEOUT_BITS'(1);

    logic [2:0]              state_r,       state_s;
    logic [2:0]              phase_r,       phase_s;
    logic [SETTLE_W-1:0]     settle_cnt_r,  settle_cnt_s;
    logic [DWELL_BITS-1:0]   dwell_cnt_r,   dwell_cnt_s;
    logic [DWELL_BITS:0]     hits_r,        hits_s;
    logic [DWELL_BITS:0]     scan_best_r,   scan_best_s;
    logic [2:0]              scan_phase_r,  scan_phase_s;
    logic [TIMEOUT_BITS-1:0] timeout_cnt_r, timeout_cnt_s;
    logic [DWELL_BITS:0]     best_hits_r,   best_hits_s;
    logic [7:0]              loss_r,        loss_s;
    logic                    valid_r;
    logic                    scanning_r,    scanning_s;
    logic                    hit_s;

    function automatic logic is_ctrl_word(input logic [9:0] w);
        case (w)
            10'h354, 10'h0AB, 10'h154, 10'h2AB: is_ctrl_word = 1'b1;
            default:                            is_ctrl_word = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] loss_sat_inc(input logic [7:0] v);
        if (v != 8'hFF) begin
            loss_sat_inc = v + 8'd1;
        end else begin
            loss_sat_inc = v;
        end
    endfunction

    assign hit_s = is_ctrl_word(in);

    // Next-state and datapath decode for the scan / lock sequencer
    always_comb begin
        state_s       = state_r;
        phase_s       = phase_r;
        settle_cnt_s  = settle_cnt_r;
        dwell_cnt_s   = dwell_cnt_r;
        hits_s        = hits_r;
        scan_best_s   = scan_best_r;
        scan_phase_s  = scan_phase_r;
        timeout_cnt_s = timeout_cnt_r;
        best_hits_s   = best_hits_r;
        loss_s        = loss_r;
        if ((state_r != ST_IDLE) && !pll_locked) begin
            state_s       = ST_IDLE;
            phase_s       = 3'd0;
            settle_cnt_s  = '0;
            dwell_cnt_s   = '0;
            hits_s        = '0;
            timeout_cnt_s = '0;
            if (state_r == ST_LOCKED) begin
                loss_s = loss_sat_inc(loss_r);
            end else begin
                loss_s = loss_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    phase_s       = 3'd0;
                    settle_cnt_s  = '0;
                    dwell_cnt_s   = '0;
                    hits_s        = '0;
                    scan_best_s   = '0;
                    scan_phase_s  = 3'd0;
                    timeout_cnt_s = '0;
                    if (pll_locked) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    hits_s      = '0;
                    dwell_cnt_s = '0;
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_s = '0;
                        state_s      = ST_MEASURE;
                    end else begin
                        settle_cnt_s = settle_cnt_r + SETTLE_ONE;
                    end
                end
                ST_MEASURE: begin
                    // At most 2^DWELL_BITS hits fit in the extra counter bit
                    if (hit_s) begin
                        hits_s = hits_r + HITS_ONE;
                    end else begin
                        hits_s = hits_r;
                    end
                    if (dwell_cnt_r == '1) begin
                        dwell_cnt_s = '0;
                        state_s     = ST_EVAL;
                    end else begin
                        dwell_cnt_s = dwell_cnt_r + DWELL_ONE;
                    end
                end
                ST_EVAL: begin
                    if (hits_r > scan_best_r) begin
                        scan_best_s  = hits_r;
                        scan_phase_s = phase_r;
                    end else begin
                        scan_best_s  = scan_best_r;
                    end
                    if (phase_r < PHASE_LAST) begin
                        phase_s = phase_r + 3'd1;
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    best_hits_s = scan_best_r;
                    if (scan_best_r >= MIN_HITS_C) begin
                        phase_s = scan_phase_r;
                        state_s = ST_APPLY;
                    end else begin
                        phase_s      = 3'd0;
                        scan_best_s  = '0;
                        scan_phase_s = 3'd0;
                        state_s      = ST_SETTLE;
                    end
                end
                ST_APPLY: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_s  = '0;
                        timeout_cnt_s = '0;
                        state_s       = ST_LOCKED;
                    end else begin
                        settle_cnt_s = settle_cnt_r + SETTLE_ONE;
                    end
                end
                ST_LOCKED: begin
                    // A hit on the terminal-count cycle still keeps the lock
                    if (hit_s) begin
                        timeout_cnt_s = '0;
                    end else if (timeout_cnt_r == '1) begin
                        timeout_cnt_s = '0;
                        settle_cnt_s  = '0;
                        scan_best_s   = '0;
                        scan_phase_s  = 3'd0;
                        phase_s       = 3'd0;
                        loss_s        = loss_sat_inc(loss_r);
                        state_s       = ST_SETTLE;
                    end else begin
                        timeout_cnt_s = timeout_cnt_r + TIMEOUT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    phase_s = 3'd0;
                end
            endcase
        end
    end

    // Scanning flag decoded from the upcoming state so the output is registered
    always_comb begin
        case (state_s)
            ST_SETTLE, ST_MEASURE, ST_EVAL, ST_DECIDE, ST_APPLY: scanning_s = 1'b1;
            default:                                             scanning_s = 1'b0;
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            phase_r       <= 3'd0;
            settle_cnt_r  <= '0;
            dwell_cnt_r   <= '0;
            hits_r        <= '0;
            scan_best_r   <= '0;
            scan_phase_r  <= 3'd0;
            timeout_cnt_r <= '0;
            best_hits_r   <= '0;
            loss_r        <= 8'd0;
            valid_r       <= 1'b0;
            scanning_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            phase_r       <= phase_s;
            settle_cnt_r  <= settle_cnt_s;
            dwell_cnt_r   <= dwell_cnt_s;
            hits_r        <= hits_s;
            scan_best_r   <= scan_best_s;
            scan_phase_r  <= scan_phase_s;
            timeout_cnt_r <= timeout_cnt_s;
            best_hits_r   <= best_hits_s;
            loss_r        <= loss_s;
            valid_r       <= (state_s == ST_LOCKED);
            scanning_r    <= scanning_s;
        end
    end

    assign phase      = phase_r;
    assign valid      = valid_r;
    assign scanning   = scanning_r;
    assign best_hits  = best_hits_r;
    assign loss_count = loss_r;

endmodule

// File: tb/tb_tmds_phase_controller.sv
// Bench for tmds_phase_controller: a timeline model of scan/lock behaviour checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_tmds_phase_controller;

    logic       hdmi_clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic [9:0] din;
    logic [2:0] phase;
    logic       valid;
    logic       scanning;
    logic [4:0] best_hits;
    logic [7:0] loss_count;

    logic [4:0] profile;   // phases on which the source delivers control words
    logic       kill;      // suppress every control word

    int n_checks = 0;
    int n_errors = 0;

    always #5 hdmi_clk = ~hdmi_clk;

    tmds_phase_controller #(
        .PHASES(5), .SETTLE_CYCLES(4), .DWELL_BITS(4), .MIN_HITS(8), .TIMEOUT_BITS(6)
    ) dut (
        .hdmi_clk(hdmi_clk), .reset(reset), .pll_locked(pll_locked), .in(din),
        .phase(phase), .valid(valid), .scanning(scanning),
        .best_hits(best_hits), .loss_count(loss_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_ctrl(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // Source: control word only while the selected phase is a "good" one
    initial begin
        din = 10'h1F0;
        forever begin
            @(posedge hdmi_clk);
            #2;
            if (!kill && (phase < 3'd5) && profile[phase]) din = 10'h354;
            else din = 10'h1F0;
        end
    end

    // ---------------- timeline model ----------------
    typedef struct packed {
        logic [2:0] ph;
        logic       scan;
        logic [4:0] bh;
    } exp_t;

    exp_t       exp_q[$];
    int         m_mode = 0;          // 0 idle, 1 scan timeline, 2 locked
    logic       m_ok = 1'b0;
    logic [2:0] m_lock_ph = 3'd0;
    logic [4:0] m_lock_bh = 5'd0;
    logic [4:0] m_next_bh = 5'd0;
    int         m_quiet = 0;
    logic       e_valid = 1'b0;
    logic       e_scan = 1'b0;
    logic [2:0] e_phase = 3'd0;
    logic [4:0] e_bh = 5'd0;
    logic [7:0] e_loss = 8'd0;

    // One full scan: 5 phases x (4 settle + 16 measure + 1 eval), a decide cycle,
    // then 4 apply cycles if the best phase saw at least 8 control words.
    task automatic build_scan(input logic [4:0] bh_before);
        int hits[5];
        int best = 0;
        int bp = 0;
        for (int p = 0; p < 5; p++) hits[p] = (profile[p] && !kill) ? 16 : 0;
        for (int p = 0; p < 5; p++) if (hits[p] > best) begin best = hits[p]; bp = p; end
        for (int p = 0; p < 5; p++)
            for (int i = 0; i < 21; i++) exp_q.push_back('{3'(p), 1'b1, bh_before});
        exp_q.push_back('{3'd4, 1'b1, bh_before});
        if (best >= 8) begin
            for (int i = 0; i < 4; i++) exp_q.push_back('{3'(bp), 1'b1, 5'(best)});
            m_ok = 1'b1; m_lock_ph = 3'(bp); m_lock_bh = 5'(best);
        end else begin
            m_ok = 1'b0; m_next_bh = 5'(best);
        end
    endtask

    task automatic pop_entry();
        exp_t e;
        e = exp_q.pop_front();
        e_phase = e.ph; e_scan = e.scan; e_bh = e.bh; e_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge hdmi_clk or posedge reset);
            if (reset) begin
                exp_q.delete(); m_mode = 0; m_quiet = 0;
                e_valid = 1'b0; e_scan = 1'b0; e_phase = 3'd0; e_bh = 5'd0; e_loss = 8'd0;
            end else if (m_mode != 0 && !pll_locked) begin
                if (m_mode == 2 && e_loss != 8'hFF) e_loss = e_loss + 8'd1;
                exp_q.delete(); m_mode = 0;
                e_valid = 1'b0; e_scan = 1'b0; e_phase = 3'd0;
            end else if (m_mode == 0) begin
                if (pll_locked) begin build_scan(e_bh); m_mode = 1; pop_entry(); end
            end else if (m_mode == 1) begin
                if (exp_q.size() != 0) pop_entry();
                else if (m_ok) begin
                    m_mode = 2; m_quiet = 0;
                    e_valid = 1'b1; e_scan = 1'b0; e_phase = m_lock_ph; e_bh = m_lock_bh;
                end else begin
                    build_scan(m_next_bh); pop_entry();
                end
            end else begin
                if (is_ctrl(din)) m_quiet = 0;
                else begin
                    m_quiet++;
                    if (m_quiet == 64) begin
                        if (e_loss != 8'hFF) e_loss = e_loss + 8'd1;
                        build_scan(e_bh); m_mode = 1; pop_entry();
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge hdmi_clk);
            chk("cyc_valid",     int'(valid),      int'(e_valid));
            chk("cyc_scanning",  int'(scanning),   int'(e_scan));
            chk("cyc_phase",     int'(phase),      int'(e_phase));
            chk("cyc_best_hits", int'(best_hits),  int'(e_bh));
            chk("cyc_loss",      int'(loss_count), int'(e_loss));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge hdmi_clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; pll_locked = 1'b0; profile = 5'b00000; kill = 1'b0;
        #23 reset = 1'b0;
        edges(3);
        chk("idle_phase", int'(phase), 0);
        chk("idle_scanning", int'(scanning), 0);

        // Only phase 3 carries control words: lock after 1+5*21+1+4 cycles
        profile = 5'b01000; pll_locked = 1'b1;
        edges(110);
        chk("a_valid_early", int'(valid), 0);
        chk("a_scanning_early", int'(scanning), 1);
        edges(1);
        chk("a_valid", int'(valid), 1);
        chk("a_phase", int'(phase), 3);
        chk("a_best_hits", int'(best_hits), 16);
        chk("a_scanning", int'(scanning), 0);
        edges(20);
        chk("a_hold_valid", int'(valid), 1);

        // Remove control words: 64 hit-free cycles drop the lock
        kill = 1'b1;
        edges(63);
        chk("to_valid_63", int'(valid), 1);
        edges(1);
        chk("to_valid", int'(valid), 0);
        chk("to_loss", int'(loss_count), 1);
        chk("to_scanning", int'(scanning), 1);
        chk("to_phase", int'(phase), 0);

        // No control words: phases step 0..4 and the failed decide restarts at 0
        edges(21); chk("nc_phase1", int'(phase), 1);
        edges(21); chk("nc_phase2", int'(phase), 2);
        edges(21); chk("nc_phase3", int'(phase), 3);
        edges(21); chk("nc_phase4", int'(phase), 4);
        edges(21);
        chk("nc_decide_phase", int'(phase), 4);
        chk("nc_decide_bh", int'(best_hits), 16);
        edges(1);
        chk("nc_rescan_phase", int'(phase), 0);
        chk("nc_rescan_bh", int'(best_hits), 0);
        chk("nc_rescan_valid", int'(valid), 0);
        chk("nc_rescan_scanning", int'(scanning), 1);

        // Asynchronous reset in the middle of a measurement window
        edges(10);
        #2 reset = 1'b1;
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_scanning", int'(scanning), 0);
        chk("rst_best_hits", int'(best_hits), 0);
        chk("rst_loss", int'(loss_count), 0);
        profile = 5'b01010; kill = 1'b0;
        #2 reset = 1'b0;

        // Phases 1 and 3 tie at 16 hits: the lower phase wins
        edges(110);
        chk("tie_valid_early", int'(valid), 0);
        edges(1);
        chk("tie_valid", int'(valid), 1);
        chk("tie_phase", int'(phase), 1);
        chk("tie_best_hits", int'(best_hits), 16);
        chk("tie_loss", int'(loss_count), 0);

        // PLL loss while locked
        edges(5);
        pll_locked = 1'b0;
        edges(1);
        chk("pll_valid", int'(valid), 0);
        chk("pll_phase", int'(phase), 0);
        chk("pll_scanning", int'(scanning), 0);
        chk("pll_loss", int'(loss_count), 1);

        // PLL loss during the phase-2 eval cycle, then a full rescan
        profile = 5'b01000; pll_locked = 1'b1;
        edges(63);
        chk("ev_phase", int'(phase), 2);
        chk("ev_scanning", int'(scanning), 1);
        pll_locked = 1'b0;
        edges(1);
        chk("ev_idle_phase", int'(phase), 0);
        chk("ev_idle_valid", int'(valid), 0);
        chk("ev_idle_scanning", int'(scanning), 0);
        chk("ev_idle_loss", int'(loss_count), 1);
        pll_locked = 1'b1;
        edges(111);
        chk("relock_valid", int'(valid), 1);
        chk("relock_phase", int'(phase), 3);
        chk("relock_best_hits", int'(best_hits), 16);
        edges(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
